// File: rtl/request_issuer_pkg.sv
// Shared definitions for the request issuer: FSM encoding, buffer depth and the
// default watchdog limit.
package request_issuer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issuer_state_e;

  localparam logic [1:0] BUFFER_DEPTH           = 2'd2;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/issuer_skid_buffer.sv
// Two-entry FIFO between the upstream source and the issuer FSM.
// Flush keeps only the head entry when keep_head is set.
module issuer_skid_buffer
  import request_issuer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  input  logic             keep_head,
  output logic [1:0]       occupancy,
  output logic             ready,
  output logic [WIDTH-1:0] head_data,
  output logic [WIDTH-1:0] second_data
);

  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;
  logic [1:0]       occupancy_next;

  // Tail is implied by head and occupancy, so it needs no register of its own.
  assign tail        = head ^ occupancy[0];
  assign head_data   = mem[head];
  assign second_data = mem[~head];

  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    occupancy_next = occupancy;
    if (flush) begin
      occupancy_next = keep_head ? 2'd1 : 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   occupancy_next = occupancy + 2'd1;
        2'b01:   occupancy_next = occupancy - 2'd1;
        default: occupancy_next = occupancy;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      head      <= 1'b0;
      occupancy <= 2'd0;
      ready     <= 1'b1;
    end else begin
      if (pop) head <= ~head;
      occupancy <= occupancy_next;
      ready     <= (occupancy_next != BUFFER_DEPTH);
    end
  end

  // NOTE: payload storage is not reset; occupancy alone says which slots are valid.
  always_ff @(posedge clk_in) begin
    if (push && !flush) mem[tail] <= push_data;
  end

endmodule

// File: rtl/request_issuer.sv
// Presents buffered requests one at a time to the queue write port, holding each
// until acked, with a sticky ack-latency watchdog and a retired-request counter.
module request_issuer
  import request_issuer_pkg::*;
#(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32,
  parameter int TIMEOUT_CYCLES             = DEFAULT_TIMEOUT_CYCLES,
  parameter int TIMEOUT_CNT_WIDTH_IN_BITS  = 9,
  parameter int ISSUE_CNT_WIDTH_IN_BITS    = 16
) (
  input  logic                                  clk_in,
  input  logic                                  reset_n_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] src_request_in,
  input  logic                                  src_valid_in,
  output logic                                  src_ready_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
  output logic                                  request_valid_out,
  input  logic                                  issue_ack_in,
  input  logic                                  flush_in,
  output logic                                  timeout_error_out,
  output logic [ISSUE_CNT_WIDTH_IN_BITS-1:0]    issued_count_out
);

  localparam logic [TIMEOUT_CNT_WIDTH_IN_BITS-1:0] TIMEOUT_LIMIT =
    TIMEOUT_CNT_WIDTH_IN_BITS'(TIMEOUT_CYCLES);

  issuer_state_e                           state;
  logic [1:0]                              occupancy;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]   head_data;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]   second_data;
  logic                                    push;
  logic                                    pop;
  logic                                    keep_head;
  logic [TIMEOUT_CNT_WIDTH_IN_BITS-1:0]    watchdog;
  logic [TIMEOUT_CNT_WIDTH_IN_BITS-1:0]    watchdog_next;

  // Upstream data arriving in a flush cycle is dropped, as are acks outside ISSUE.
  assign push      = src_valid_in & src_ready_out & ~flush_in;
  assign pop       = (state == ISSUE) & issue_ack_in;
  assign keep_head = (state == ISSUE) & ~issue_ack_in;

  issuer_skid_buffer #(
    .WIDTH(SINGLE_ENTRY_WIDTH_IN_BITS)
  ) u_buffer (
    .clk_in      (clk_in),
    .reset_n_in  (reset_n_in),
    .push        (push),
    .push_data   (src_request_in),
    .pop         (pop),
    .flush       (flush_in),
    .keep_head   (keep_head),
    .occupancy   (occupancy),
    .ready       (src_ready_out),
    .head_data   (head_data),
    .second_data (second_data)
  );

  always_comb begin
    watchdog_next = watchdog;
    if (state == ISSUE) begin
      if (issue_ack_in)                 watchdog_next = '0;
      else if (watchdog != TIMEOUT_LIMIT) watchdog_next = watchdog + TIMEOUT_CNT_WIDTH_IN_BITS'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state             <= IDLE;
      request_out       <= '0;
      request_valid_out <= 1'b0;
      watchdog          <= '0;
      timeout_error_out <= 1'b0;
      issued_count_out  <= '0;
    end else begin
      watchdog <= watchdog_next;
      if (watchdog_next == TIMEOUT_LIMIT) timeout_error_out <= 1'b1;

      case (state)
        IDLE: begin
          if (occupancy != 2'd0 && !flush_in) begin
            state             <= ISSUE;
            request_out       <= head_data;
            request_valid_out <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_ack_in) begin
            issued_count_out <= issued_count_out + ISSUE_CNT_WIDTH_IN_BITS'(1);
            // The next head is either the older buffered entry or a same-cycle push.
            if (!flush_in && (occupancy == BUFFER_DEPTH || push)) begin
              request_out <= (occupancy == BUFFER_DEPTH) ? second_data : src_request_in;
            end else begin
              state             <= IDLE;
              request_valid_out <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_request_issuer.sv
// Self-checking bench for request_issuer: directed vector table, hand sequences for
// timeout/flush/reset, a random run against a queue-based model, and a streaming sink.
module tb_request_issuer;

  localparam int TO = 8;
  localparam int CW = 4;

  logic        clk;
  logic        reset_n_in;
  logic [31:0] src_request_in;
  logic        src_valid_in;
  logic        src_ready_out;
  logic [31:0] request_out;
  logic        request_valid_out;
  logic        issue_ack_in;
  logic        flush_in;
  logic        timeout_error_out;
  logic [CW-1:0] issued_count_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_on = 0;

  // Reference model: pending entries in arrival order, oldest one is the presented one.
  bit [31:0] mq[$];
  bit        m_presented;
  bit [31:0] m_req;
  int        m_count;
  int        m_wait;
  bit        m_err;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ack;
    logic        flush;
    logic        e_valid;
    logic [31:0] e_req;
    logic        e_ready;
    logic [3:0]  e_count;
  } vec_t;

  vec_t tbl[13];

  bit [31:0] writes[$];
  bit        pending_ack;
  int        last_ack;
  int        idx;
  bit        xfer;

  request_issuer #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(32),
    .TIMEOUT_CYCLES            (TO),
    .TIMEOUT_CNT_WIDTH_IN_BITS (9),
    .ISSUE_CNT_WIDTH_IN_BITS   (CW)
  ) dut (
    .clk_in           (clk),
    .reset_n_in       (reset_n_in),
    .src_request_in   (src_request_in),
    .src_valid_in     (src_valid_in),
    .src_ready_out    (src_ready_out),
    .request_out      (request_out),
    .request_valid_out(request_valid_out),
    .issue_ack_in     (issue_ack_in),
    .flush_in         (flush_in),
    .timeout_error_out(timeout_error_out),
    .issued_count_out (issued_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_presented = 0;
    m_req       = '0;
    m_count     = 0;
    m_wait      = 0;
    m_err       = 0;
  endtask

  task automatic model_step();
    bit accept;
    accept = src_valid_in && (mq.size() != 2) && !flush_in;
    if (m_presented) begin
      if (issue_ack_in) begin
        void'(mq.pop_front());
        m_count++;
        m_wait = 0;
        if (flush_in) begin
          mq.delete();
          m_presented = 0;
        end else begin
          if (accept) mq.push_back(src_request_in);
          m_presented = (mq.size() != 0);
          if (m_presented) m_req = mq[0];
        end
      end else begin
        if (m_wait < TO) m_wait++;
        if (m_wait >= TO) m_err = 1;
        if (flush_in) begin
          while (mq.size() > 1) void'(mq.pop_back());
        end else if (accept) begin
          mq.push_back(src_request_in);
        end
      end
    end else begin
      if (flush_in) begin
        mq.delete();
      end else begin
        if (mq.size() != 0) begin
          m_presented = 1;
          m_req       = mq[0];
        end
        if (accept) mq.push_back(src_request_in);
      end
    end
  endtask

  task automatic compare_model();
    check("model_valid", request_valid_out, m_presented);
    if (m_presented) check("model_req", request_out, m_req);
    check("model_ready", src_ready_out, mq.size() != 2);
    check("model_count", issued_count_out, m_count % (1 << CW));
    check("model_err", timeout_error_out, m_err);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (model_on) compare_model();
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ack, input logic fl);
    src_valid_in   = v;
    src_request_in = d;
    issue_ack_in   = ack;
    flush_in       = fl;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    #1;
    reset_n_in = 1'b0;
    #1;
    check("reset_valid", request_valid_out, 0);
    check("reset_ready", src_ready_out, 1);
    check("reset_count", issued_count_out, 0);
    check("reset_err", timeout_error_out, 0);
    check("reset_req", request_out, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n_in = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_n_in = 1'b1;
    drive(0, 0, 0, 0);
    #3;
    do_reset();

    // Single request followed by three back-to-back pushes against a 2-entry buffer.
    tbl[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 4'd0};
    tbl[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 4'd0};
    tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 4'd0};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 4'd1};
    tbl[4]  = '{1'b1, 32'h1,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 4'd1};
    tbl[5]  = '{1'b1, 32'h2,        1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 4'd1};
    tbl[6]  = '{1'b1, 32'h3,        1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 4'd1};
    tbl[7]  = '{1'b1, 32'h3,        1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 4'd1};
    tbl[8]  = '{1'b1, 32'h3,        1'b1, 1'b0, 1'b1, 32'h2,        1'b1, 4'd2};
    tbl[9]  = '{1'b1, 32'h3,        1'b0, 1'b0, 1'b1, 32'h2,        1'b0, 4'd2};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h3,        1'b1, 4'd3};
    tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h3,        1'b1, 4'd3};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 4'd4};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].ack, tbl[i].flush);
      cycle();
      check($sformatf("tbl%0d_valid", i), request_valid_out, tbl[i].e_valid);
      if (tbl[i].e_valid) check($sformatf("tbl%0d_req", i), request_out, tbl[i].e_req);
      check($sformatf("tbl%0d_ready", i), src_ready_out, tbl[i].e_ready);
      check($sformatf("tbl%0d_count", i), issued_count_out, tbl[i].e_count);
      check($sformatf("tbl%0d_err", i), timeout_error_out, 0);
    end

    // Watchdog: 0xA5 presented with the ack withheld.
    drive(1, 32'hA5, 0, 0);
    cycle();
    drive(0, 0, 0, 0);
    for (int k = 0; k < 4 && !request_valid_out; k++) cycle();
    check("to_present", request_valid_out, 1);
    for (int k = 1; k <= TO + 3; k++) begin
      cycle();
      check($sformatf("to_err_k%0d", k), timeout_error_out, (k >= TO) ? 1 : 0);
      check("to_req_held", request_out, 32'hA5);
      check("to_valid_held", request_valid_out, 1);
    end
    drive(0, 0, 1, 0);
    cycle();
    drive(0, 0, 0, 0);
    check("to_late_ack_valid", request_valid_out, 0);
    check("to_late_ack_count", issued_count_out, 5);
    check("to_err_sticky", timeout_error_out, 1);

    // Reset while an entry is presented drops it; count and error clear.
    drive(1, 32'h77, 0, 0);
    cycle();
    drive(0, 0, 0, 0);
    cycle();
    check("mid_reset_presented", request_valid_out, 1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("mid_reset_no_issue", request_valid_out, 0);
    end

    // Flush with two entries in ISSUE: presented entry survives, second is discarded.
    drive(1, 32'h11, 0, 0); cycle();
    drive(1, 32'h22, 0, 0); cycle();
    check("fl_present", request_out, 32'h11);
    check("fl_full", src_ready_out, 0);
    drive(0, 0, 0, 1); cycle();
    check("fl_keep_valid", request_valid_out, 1);
    check("fl_keep_req", request_out, 32'h11);
    check("fl_ready", src_ready_out, 1);
    drive(0, 0, 0, 0); cycle();
    check("fl_hold_req", request_out, 32'h11);
    drive(0, 0, 1, 0); cycle();
    check("fl_ack_idle", request_valid_out, 0);
    check("fl_ack_count", issued_count_out, 1);
    drive(0, 0, 0, 0); cycle(); cycle();
    check("fl_discarded", request_valid_out, 0);

    // Flush and ack in the same cycle empty everything.
    drive(1, 32'h33, 0, 0); cycle();
    drive(1, 32'h44, 0, 0); cycle();
    check("flack_present", request_out, 32'h33);
    drive(0, 0, 1, 1); cycle();
    check("flack_idle", request_valid_out, 0);
    check("flack_count", issued_count_out, 2);
    check("flack_ready", src_ready_out, 1);
    drive(0, 0, 0, 0); cycle(); cycle();
    check("flack_empty", request_valid_out, 0);

    // An upstream transfer during flush is discarded; an ack in IDLE is ignored.
    drive(1, 32'h55, 1, 1); cycle();
    drive(0, 0, 1, 0); cycle();
    drive(0, 0, 0, 0); cycle();
    check("flpush_dropped", request_valid_out, 0);
    check("idle_ack_ignored", issued_count_out, 2);

    // Random traffic against the model (counter wraps several times).
    model_on = 1;
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
      cycle();
    end

    // Stream 10 requests into a write-side sink that acks one cycle after each write.
    do_reset();
    writes.delete();
    pending_ack = 0;
    last_ack    = -1;
    idx         = 0;
    for (int c = 0; c < 100 && !(writes.size() == 10 && !pending_ack && !request_valid_out); c++) begin
      issue_ack_in = pending_ack;
      if (pending_ack) begin
        if (last_ack >= 0) check("stream_ack_spacing", cyc - last_ack, 2);
        last_ack = cyc;
      end
      pending_ack = request_valid_out && !issue_ack_in;
      if (pending_ack) writes.push_back(request_out);
      src_valid_in   = (idx < 10);
      src_request_in = 32'h100 + idx;
      flush_in       = 1'b0;
      xfer           = src_valid_in && src_ready_out;
      cycle();
      if (xfer) idx++;
    end
    check("stream_write_count", writes.size(), 10);
    for (int i = 0; i < 10 && i < writes.size(); i++) begin
      check($sformatf("stream_write%0d", i), writes[i], 32'h100 + i);
    end
    check("stream_retired", issued_count_out, 10);
    model_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
